// File: rtl/btle_crc24_gen.sv
// Bit-serial BLE link-layer CRC-24 generator.
// Leading preamble/access-address bits pass straight through. PDU bits pass
// through and also feed the CRC LFSR. After the last PDU bit, the 24 CRC bits
// are appended MSB-first, one every CRC_OUT_GAP cycles.
// Optional build macro BTLE_CRC24_STATE_PORT_EN adds the crc_state and
// crc_append_busy observation ports.
module btle_crc24_gen #(
  parameter int unsigned CRC_STATE_BIT_WIDTH = 24,  // only 24 is supported
  parameter int unsigned BYPASS_BIT_COUNT    = 40,
  parameter int unsigned CRC_OUT_GAP         = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
  input  logic                           crc_state_init_bit_load,
  input  logic                           info_bit,
  input  logic                           info_bit_valid,
  input  logic                           info_bit_valid_last,
  output logic                           info_bit_after_crc24,
  output logic                           info_bit_after_crc24_valid,
`ifdef BTLE_CRC24_STATE_PORT_EN
  output logic                           info_bit_after_crc24_valid_last,
  output logic [CRC_STATE_BIT_WIDTH-1:0] crc_state,
  output logic                           crc_append_busy
`else
  output logic                           info_bit_after_crc24_valid_last
`endif
);

  localparam int unsigned W     = CRC_STATE_BIT_WIDTH;
  localparam int unsigned CNT_W = $clog2(BYPASS_BIT_COUNT + 1);
  localparam int unsigned GAP_W = $clog2(CRC_OUT_GAP + 1);
  localparam int unsigned IDX_W = $clog2(CRC_STATE_BIT_WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE_PASS = 1'b0,
    ST_APPEND    = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     init_q, init_d;
  logic [W-1:0]     lfsr_q, lfsr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0] crc_idx_q, crc_idx_d;
  logic             out_bit_q, out_bit_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  // One LFSR step for x^24+x^10+x^9+x^6+x^4+x^3+x+1
  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s, input logic d);
    logic          fb;
    logic [W-1:0]  n;
    fb    = s[W-1] ^ d;
    n     = {s[W-2:0], fb};
    n[1]  = n[1]  ^ fb;
    n[3]  = n[3]  ^ fb;
    n[4]  = n[4]  ^ fb;
    n[6]  = n[6]  ^ fb;
    n[9]  = n[9]  ^ fb;
    n[10] = n[10] ^ fb;
    return n;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE_PASS;
      init_q      <= '0;
      lfsr_q      <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      crc_idx_q   <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_q      <= init_d;
      lfsr_q      <= lfsr_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      crc_idx_q   <= crc_idx_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // Next-state: pass-through with CRC update, then paced CRC append
  always_comb begin
    state_d     = state_q;
    init_d      = init_q;
    lfsr_d      = lfsr_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    crc_idx_d   = crc_idx_q;
    out_bit_d   = out_bit_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;

    unique case (state_q)
      ST_IDLE_PASS: begin
        if (info_bit_valid) begin
          out_bit_d   = info_bit;
          out_valid_d = 1'b1;
          // Counter saturates at the bypass length; once there, bits are PDU
          if (bit_cnt_q >= CNT_W'(BYPASS_BIT_COUNT)) begin
            lfsr_d = lfsr_step(lfsr_q, info_bit);
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (info_bit_valid_last) begin
            state_d   = ST_APPEND;
            gap_cnt_d = '0;
            crc_idx_d = '0;
          end
        end
      end
      ST_APPEND: begin
        if (gap_cnt_q == GAP_W'(CRC_OUT_GAP - 1)) begin
          gap_cnt_d   = '0;
          out_bit_d   = lfsr_q[W-1];
          out_valid_d = 1'b1;
          lfsr_d      = {lfsr_q[W-2:0], 1'b0};
          if (crc_idx_q == IDX_W'(W - 1)) begin
            out_last_d = 1'b1;
            state_d    = ST_IDLE_PASS;
            bit_cnt_d  = '0;
            crc_idx_d  = '0;
            lfsr_d     = init_q;
          end else begin
            crc_idx_d = crc_idx_q + IDX_W'(1);
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE_PASS;
    endcase

    // Init load overrides any LFSR update in the same cycle
    if (crc_state_init_bit_load) begin
      init_d = crc_state_init_bit;
      lfsr_d = crc_state_init_bit;
    end
  end

  assign info_bit_after_crc24            = out_bit_q;
  assign info_bit_after_crc24_valid      = out_valid_q;
  assign info_bit_after_crc24_valid_last = out_last_q;

`ifdef BTLE_CRC24_STATE_PORT_EN
  assign crc_state       = lfsr_q;
  assign crc_append_busy = (state_q == ST_APPEND);
`endif

endmodule

// File: tb/tb_btle_crc24_gen.sv
// Scoreboard bench for btle_crc24_gen: every expected output bit, with its
// last flag and the cycle it must appear in, is queued when stimulus is driven.
module tb_btle_crc24_gen;

  localparam int unsigned GAP = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] init_val = '0;
  logic        init_load = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_bit;
  logic        out_valid;
  logic        out_last;
`ifdef BTLE_CRC24_STATE_PORT_EN
  logic [23:0] crc_state;
  logic        crc_append_busy;
`endif

  btle_crc24_gen dut (
    .clk                             (clk),
    .rst                             (rst),
    .crc_state_init_bit              (init_val),
    .crc_state_init_bit_load         (init_load),
    .info_bit                        (in_bit),
    .info_bit_valid                  (in_valid),
    .info_bit_valid_last             (in_last),
    .info_bit_after_crc24            (out_bit),
    .info_bit_after_crc24_valid      (out_valid),
`ifdef BTLE_CRC24_STATE_PORT_EN
    .info_bit_after_crc24_valid_last (out_last),
    .crc_state                       (crc_state),
    .crc_append_busy                 (crc_append_busy)
`else
    .info_bit_after_crc24_valid_last (out_last)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic last;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  logic fq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference CRC step in shift-and-mask form
  function automatic logic [23:0] crc_ref(input logic [23:0] s, input logic d);
    logic fb;
    fb = s[23] ^ d;
    return (s << 1) ^ (fb ? 24'h00065B : 24'h000000);
  endfunction

  // Compare every emitted bit against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      exp_t e;
      check("sb_has_entry", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_bit", 32'(out_bit), 32'(e.b));
        check("out_last", 32'(out_last), 32'(e.last));
        check("out_cyc", 32'(cyc), 32'(e.cyc));
      end
    end else if (!rst && out_last) begin
      check("last_without_valid", 32'(out_last), 0);
    end
  end

  task automatic do_load(input logic [23:0] v);
    @(negedge clk);
    init_val  = v;
    init_load = 1'b1;
    @(negedge clk);
    init_load = 1'b0;
  endtask

  // Fill fq with the 40 bypass bits (0xAA then 0x71764129, LSB-first)
  task automatic fill_bypass();
    logic [39:0] v;
    v = {32'h71764129, 8'hAA};
    fq.delete();
    for (int i = 0; i < 40; i++) fq.push_back(v[i]);
  endtask

  // Drive fq as one frame and queue expected output; optional load at bit
  // load_idx, optional valid pulses during append, optional reset mid-append
  task automatic send_frame(input int spacing, input int load_idx, input logic [23:0] load_val,
                            input logic [23:0] exp_crc, input bit noise, input int abort_after);
    int   last_cyc;
    int   target;
    exp_t e;
    last_cyc = 0;
    for (int i = 0; i < fq.size(); i++) begin
      @(negedge clk);
      in_bit   = fq[i];
      in_valid = 1'b1;
      in_last  = (i == fq.size() - 1);
      if (i == load_idx) begin
        init_val  = load_val;
        init_load = 1'b1;
      end
      e.b = fq[i]; e.last = 1'b0; e.cyc = cyc + 1;
      sb.push_back(e);
      last_cyc = cyc + 1;
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'b0;
      init_load = 1'b0;
      repeat (spacing - 2) @(negedge clk);
    end
    for (int j = 0; j < 24; j++) begin
      e.b = exp_crc[23 - j]; e.last = (j == 23); e.cyc = last_cyc + GAP * (j + 1);
      sb.push_back(e);
    end
    target = (abort_after > 0) ? last_cyc + abort_after : last_cyc + GAP * 24 + 3;
    while (cyc < target) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (noise && ((cyc - last_cyc) % 5 == 0) && (cyc < last_cyc + 300)) begin
        in_bit   = ~in_bit;
        in_valid = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (abort_after > 0) begin
      #2 rst = 1'b1;
      #1;
      check("rst_mid_bit", 32'(out_bit), 0);
      check("rst_mid_valid", 32'(out_valid), 0);
      check("rst_mid_last", 32'(out_last), 0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    logic [23:0] crc;
    logic [23:0] crc_a;

    repeat (3) @(negedge clk);
    check("rst_bit", 32'(out_bit), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Pass-through only: LFSR untouched, append returns the init value
    do_load(24'h555555);
    fill_bypass();
`ifdef BTLE_CRC24_STATE_PORT_EN
    check("state_after_load", 32'(crc_state), 32'h555555);
`endif
    send_frame(16, -1, '0, 24'h555555, 1'b0, 0);

    // Zero-PDU frame with a different init
    do_load(24'h123456);
    fill_bypass();
    send_frame(16, -1, '0, 24'h123456, 1'b0, 0);

    // Single PDU bit from a zero init
    do_load(24'h000000);
    fill_bypass();
    fq.push_back(1'b1);
    send_frame(16, -1, '0, 24'h00065B, 1'b0, 0);

    // Back-to-back identical frames after a single load
    do_load(24'h555555);
    fill_bypass();
    for (int i = 0; i < 16; i++) fq.push_back(1'($urandom_range(0, 1)));
    crc_a = 24'h555555;
    for (int i = 40; i < fq.size(); i++) crc_a = crc_ref(crc_a, fq[i]);
    send_frame(3, -1, '0, crc_a, 1'b0, 0);
    send_frame(2, -1, '0, crc_a, 1'b0, 0);

    // Load strobe on PDU bit 42 wins; valid pulses during append are ignored
    fill_bypass();
    for (int i = 0; i < 8; i++) fq.push_back(1'($urandom_range(0, 1)));
    crc = 24'h0ABCDE;
    for (int i = 43; i < fq.size(); i++) crc = crc_ref(crc, fq[i]);
    send_frame(4, 42, 24'h0ABCDE, crc, 1'b1, 0);

    // Reset while CRC bits are being emitted, then a clean frame
    do_load(24'h555555);
    fill_bypass();
    for (int i = 0; i < 8; i++) fq.push_back(1'($urandom_range(0, 1)));
    crc = 24'h555555;
    for (int i = 40; i < fq.size(); i++) crc = crc_ref(crc, fq[i]);
    send_frame(2, -1, '0, crc, 1'b0, 100);
    do_load(24'h555555);
    send_frame(2, -1, '0, crc, 1'b0, 0);

    repeat (20) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btle_crc24_gen.md
Name: btle_crc24_gen

Overview:
- Bit-serial BLE link-layer CRC-24 generator in the TX chain, between the PDU bit sequencer and the whitening (scramble) stage.
- Passes the 40 preamble/access-address bits through unchanged.
- Runs the CRC LFSR over every PDU bit while passing those bits through.
- After the last PDU bit, appends the 24 CRC bits at the same bit cadence as the input.

Parameters:
- CRC_STATE_BIT_WIDTH, 24: LFSR width; only 24 is supported.
- BYPASS_BIT_COUNT, 40: leading bits passed through without CRC update (8 preamble + 32 access address).
- CRC_OUT_GAP, 16: clock cycles between successive appended CRC bits; matches 1 Mbit/s at a 16 MHz clock.

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  reset, asynchronous, active-high.
- crc_state_init_bit  in  24  CRC initial value (0x555555 for advertising channels).
- crc_state_init_bit_load  in  1  1-cycle strobe: latch init value into the init register and the LFSR.
- info_bit  in  1  serial input bit.
- info_bit_valid  in  1  qualifies info_bit, 1 cycle per bit.
- info_bit_valid_last  in  1  asserted with the valid of the final PDU bit.
- info_bit_after_crc24  out  1  serial output bit.
- info_bit_after_crc24_valid  out  1  output qualifier.
- info_bit_after_crc24_valid_last  out  1  high with the valid of the final CRC bit.

Behaviour:
- Reset (async, active-high): all outputs 0; LFSR, init register, bit counter and gap counter 0; state IDLE_PASS.
- LFSR definition, state s[23:0], per PDU bit d:
  - fb = s[23] ^ d.
  - s <= {s[22:0], fb}, then XOR fb into bits 1, 3, 4, 6, 9, 10.
  - Polynomial x^24+x^10+x^9+x^6+x^4+x^3+x+1.
- State PASS (default):
  - On each info_bit_valid, register the input to the output one cycle later: out = in, out_valid = 1.
  - Total latency is 1 cycle.
  - Increment the bit counter (saturating at BYPASS_BIT_COUNT).
  - If the counter was already >= BYPASS_BIT_COUNT before this bit, the bit is a PDU bit and updates the LFSR; otherwise the LFSR is untouched.
- Last-bit transition:
  - info_bit_valid with info_bit_valid_last: the bit is output and included in the CRC (if it is a PDU bit).
  - Then move to APPEND with gap counter cleared.
- State APPEND:
  - The first CRC bit is output CRC_OUT_GAP cycles after the last input bit's output; the following 23 bits follow every CRC_OUT_GAP cycles.
  - Output order is s[23] first; on each emitted bit shift s left.
  - out_valid pulses 1 cycle per CRC bit; out_valid_last pulses only with the 24th bit.
- End of frame: after the 24th bit return to PASS, clear the bit counter, reload the LFSR from the init register.
- Input during APPEND: input bits are ignored (not output, no CRC effect).
- valid_last during bypass: CRC is appended with the LFSR unchanged, i.e. output = init value.
- crc_state_init_bit_load:
  - Loads the init register and the LFSR in any state.
  - If it coincides with a PDU bit update, the load wins.
  - Does not alter the counters or the APPEND sequence already in progress.
- out_valid is 0 whenever no bit is emitted; the output data bit holds its last value.

Optional Feature:
- Macro BTLE_CRC24_STATE_PORT_EN.
- Defined: adds output port crc_state (24 bits) = live LFSR value, plus crc_append_busy (1 bit) = high in APPEND.
- Undefined: these ports do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset mid-APPEND:
  - Assert rst while CRC bits are being emitted → outputs 0 immediately.
  - Next frame after load 0x555555 is correct with no leftover bits.
- Pass-through: load 0x555555, send 40 bits 0xAA then 0x71764129 LSB-first, spaced 16 cycles.
  - Required: identical bits out, each 1 cycle later.
  - LFSR still 0x555555 (check via BTLE_CRC24_STATE_PORT_EN).
- Single PDU bit: load 0x000000, 40 bypass bits, then one PDU bit 1 with valid_last.
  - Required: 24 appended bits = 0x00065B MSB-first, 16 cycles apart; valid_last on bit 24 only.
- Zero-PDU frame: load 0x123456, valid_last on bypass bit 40 → appended CRC = 0x123456.
- Back-to-back frames: two identical frames with one load before the first → identical CRC both times.
- Load collision and ignored input:
  - Load strobe coinciding with a PDU bit → LFSR equals the new init value.
  - info_bit_valid during APPEND → no extra output bits.
